// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, state encoding and helpers for the FFT frame loader
package fft_pkg;

    localparam int DEF_BIT_WIDTH = 24;
    localparam int DEF_N         = 16;
    localparam int DEF_SIZE      = 4;
    localparam int DEF_BYTES     = DEF_BIT_WIDTH / 8;

    // Loader FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COLLECT   = 2'd1;
    localparam logic [1:0] ST_START     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // Bytes per Re or Im word on the serial link
    function automatic int bytes_for(input int bw);
        return bw / 8;
    endfunction

    // Reverse the low 'width' bits of v; bits above width come back as 0
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[width-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_byte_packer.sv
// rtl/fft_byte_packer.sv - assembles Re/Im sample words from a byte stream, MSB first
module fft_byte_packer
    import fft_pkg::*;
#(
    parameter int bit_width = DEF_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic [bit_width-1:0] sample_re,
    output logic [bit_width-1:0] sample_im,
    output logic                 sample_done
);

    localparam int BYTES = bytes_for(bit_width);
    localparam int NB    = 2 * BYTES;
    localparam int CW    = (NB > 1) ? $clog2(NB) : 1;

    // Only the bytes before the current one need storing; the live byte completes the word
    logic [2*bit_width-9:0] sr;
    logic [CW-1:0]          cnt;
    logic [2*bit_width-1:0] assembled;

    assign assembled   = {sr, in_byte};
    assign sample_re   = assembled[2*bit_width-1 -: bit_width];
    assign sample_im   = assembled[bit_width-1:0];
    assign sample_done = in_valid && (cnt == CW'(NB - 1));

    // Shift accepted bytes in and track position within the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (in_valid) begin
            sr  <= assembled[2*bit_width-9:0];
            cnt <= sample_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - loads N complex samples from UART bytes into an FFT (option: FFT_LOADER_TIMEOUT_EN)
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int bit_width = DEF_BIT_WIDTH,
    parameter int N         = DEF_N,
    parameter int SIZE      = DEF_SIZE,
    parameter int t_1_bit   = 5207
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    input  logic                 fft_done,
    output logic [bit_width-1:0] Re_o,
    output logic [bit_width-1:0] Im_o,
    output logic [SIZE-1:0]      invert_addr,
    output logic                 load_data,
    output logic                 start_flag,
    output logic                 busy,
    output logic                 overrun,
    output logic                 frame_err
);

    logic [1:0]           state;
    logic [SIZE-1:0]      idx;
    logic                 pk_valid;
    logic                 pk_clear;
    logic                 pk_done;
    logic [bit_width-1:0] pk_re;
    logic [bit_width-1:0] pk_im;
    logic                 done_now;
    logic                 timeout_hit;

    // Bytes are only accepted while a frame is being gathered
    assign pk_valid = rx_valid && ((state == ST_IDLE) || (state == ST_COLLECT));
    assign done_now = fft_done && (state == ST_WAIT_DONE);
    assign pk_clear = done_now || timeout_hit;
    assign busy     = (state != ST_IDLE);

    fft_byte_packer #(
        .bit_width (bit_width)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (pk_clear),
        .in_valid    (pk_valid),
        .in_byte     (rx_byte),
        .sample_re   (pk_re),
        .sample_im   (pk_im),
        .sample_done (pk_done)
    );

`ifdef FFT_LOADER_TIMEOUT_EN
    localparam int TO_LIMIT = 16 * t_1_bit;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic [TW-1:0] to_cnt;
    logic          frame_err_q;

    // Fires once the link has been silent for more than TO_LIMIT cycles mid-frame
    assign timeout_hit = (state == ST_COLLECT) && !rx_valid && (to_cnt == TW'(TO_LIMIT));
    assign frame_err   = frame_err_q;

    // Idle-gap counter, restarted by every byte and outside COLLECT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= timeout_hit;
            if ((state != ST_COLLECT) || rx_valid || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_err   = 1'b0;
`endif

    // Frame sequencing: present samples, then kick the FFT, then wait for it to finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            Re_o        <= '0;
            Im_o        <= '0;
            invert_addr <= '0;
            load_data   <= 1'b0;
            start_flag  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            load_data  <= 1'b0;
            start_flag <= 1'b0;
            overrun    <= rx_valid && ((state == ST_START) || (state == ST_WAIT_DONE));
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (timeout_hit) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else if (pk_done) begin
                        load_data   <= 1'b1;
                        Re_o        <= pk_re;
                        Im_o        <= pk_im;
                        invert_addr <= SIZE'(bit_rev(32'(idx), SIZE));
                        if (idx == SIZE'(N - 1)) begin
                            idx   <= '0;
                            state <= ST_START;
                        end else begin
                            idx <= idx + SIZE'(1);
                        end
                    end
                end
                ST_START: begin
                    // START overlaps the last load_data cycle; start_flag lands one cycle later
                    start_flag <= 1'b1;
                    state      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (fft_done) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - directed self-checking bench for fft_frame_loader
module tb_fft_frame_loader;

    localparam int BW    = 24;
    localparam int NP    = 16;
    localparam int SZ    = 4;
    localparam int T1    = 4;
    localparam int LIMIT = 16 * T1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          fft_done = 1'b0;
    logic [BW-1:0] Re_o;
    logic [BW-1:0] Im_o;
    logic [SZ-1:0] invert_addr;
    logic          load_data;
    logic          start_flag;
    logic          busy;
    logic          overrun;
    logic          frame_err;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int ld_cnt = 0;
    int sf_cnt = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int last_ld_cyc = 0;
    int last_sf_cyc = 0;
    logic [BW-1:0] ld_re   [0:255];
    logic [BW-1:0] ld_im   [0:255];
    logic [SZ-1:0] ld_addr [0:255];

    fft_frame_loader #(
        .bit_width (BW),
        .N         (NP),
        .SIZE      (SZ),
        .t_1_bit   (T1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .fft_done    (fft_done),
        .Re_o        (Re_o),
        .Im_o        (Im_o),
        .invert_addr (invert_addr),
        .load_data   (load_data),
        .start_flag  (start_flag),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle
    always @(negedge clk) begin
        if (load_data) begin
            if (ld_cnt < 256) begin
                ld_re[ld_cnt]   = Re_o;
                ld_im[ld_cnt]   = Im_o;
                ld_addr[ld_cnt] = invert_addr;
            end
            ld_cnt      = ld_cnt + 1;
            last_ld_cyc = cyc;
        end
        if (start_flag) begin
            sf_cnt      = sf_cnt + 1;
            last_sf_cyc = cyc;
        end
        if (overrun)   ov_cnt = ov_cnt + 1;
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (load_data && start_flag) both_cnt = both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [23:0] re, input logic [23:0] im);
        send_byte(re[23:16]);
        send_byte(re[15:8]);
        send_byte(re[7:0]);
        send_byte(im[23:16]);
        send_byte(im[15:8]);
        send_byte(im[7:0]);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rev_tab [0:15];
        int ldb, sfb, ovb, feb;
        logic [23:0] re_v, im_v;

        rev_tab = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

        // Reset state
        rst_n = 1'b0;
        tick(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({load_data, start_flag, overrun, frame_err}), 64'd0);
        chk("rst_re", 64'(Re_o), 64'd0);
        chk("rst_im", 64'(Im_o), 64'd0);
        chk("rst_addr", 64'(invert_addr), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Frame A: Re=k, Im=-k
        ldb = ld_cnt;
        sfb = sf_cnt;
        for (int k = 0; k < NP; k++) begin
            send_sample(24'(k), 24'(-k));
        end
        tick(3);
        chk("A_load_count", 64'(ld_cnt - ldb), 64'd16);
        chk("A_k1_addr", 64'(ld_addr[ldb+1]), 64'd8);
        chk("A_k1_re", 64'(ld_re[ldb+1]), 64'h000001);
        chk("A_k1_im", 64'(ld_im[ldb+1]), 64'hFFFFFF);
        for (int k = 0; k < NP; k++) begin
            re_v = 24'(k);
            im_v = 24'(-k);
            chk($sformatf("A_sample_%0d", k),
                {12'd0, ld_addr[ldb+k], ld_re[ldb+k], ld_im[ldb+k]},
                {12'd0, 4'(rev_tab[k]), re_v, im_v});
        end
        chk("A_start_count", 64'(sf_cnt - sfb), 64'd1);
        chk("A_start_latency", 64'(last_sf_cyc - last_ld_cyc), 64'd1);
        chk("A_busy_wait", 64'(busy), 64'd1);
        chk("A_hold_re", 64'(Re_o), 64'h00000F);
        chk("A_hold_im", 64'(Im_o), 64'hFFFFF1);
        chk("A_hold_addr", 64'(invert_addr), 64'd15);

        // Byte in WAIT_DONE is dropped with an overrun pulse
        ovb = ov_cnt;
        ldb = ld_cnt;
        send_byte(8'hAA);
        tick(2);
        chk("wd_overrun", 64'(ov_cnt - ovb), 64'd1);
        chk("wd_still_busy", 64'(busy), 64'd1);
        fft_done = 1'b1;
        tick(1);
        fft_done = 1'b0;
        tick(1);
        chk("done_idle", 64'(busy), 64'd0);
        chk("wd_no_load", 64'(ld_cnt - ldb), 64'd0);

        // Frame B: negative full-scale Re, stray fft_done mid-frame
        ldb = ld_cnt;
        sfb = sf_cnt;
        send_sample(24'h800000, 24'h7FFFFF);
        for (int k = 1; k < NP - 1; k++) begin
            if (k == 4) begin
                fft_done = 1'b1;
                tick(1);
                fft_done = 1'b0;
            end
            send_sample(24'(k << 8), 24'(k));
        end
        send_sample(24'hABCDEF, 24'h010203);
        tick(3);
        chk("B_load_count", 64'(ld_cnt - ldb), 64'd16);
        chk("B_first", {12'd0, ld_addr[ldb], ld_re[ldb], ld_im[ldb]},
            {12'd0, 4'd0, 24'h800000, 24'h7FFFFF});
        chk("B_re_signed", 64'($signed(ld_re[ldb])), 64'(-8388608));
        chk("B_k5", {12'd0, ld_addr[ldb+5], ld_re[ldb+5], ld_im[ldb+5]},
            {12'd0, 4'd10, 24'h000500, 24'h000005});
        chk("B_last", {12'd0, ld_addr[ldb+15], ld_re[ldb+15], ld_im[ldb+15]},
            {12'd0, 4'd15, 24'hABCDEF, 24'h010203});
        chk("B_start_count", 64'(sf_cnt - sfb), 64'd1);

        // rx_valid coincident with fft_done
        ovb = ov_cnt;
        ldb = ld_cnt;
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        fft_done = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        fft_done = 1'b0;
        tick(1);
        chk("coinc_overrun", 64'(ov_cnt - ovb), 64'd1);
        chk("coinc_idle", 64'(busy), 64'd0);

        // Stall after three bytes
        feb = fe_cnt;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        tick(LIMIT + 3);
`ifdef FFT_LOADER_TIMEOUT_EN
        chk("to_frame_err", 64'(fe_cnt - feb), 64'd1);
        chk("to_idle", 64'(busy), 64'd0);
`else
        chk("no_to_frame_err", 64'(fe_cnt - feb), 64'd0);
        chk("no_to_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
`endif
        chk("stall_no_load", 64'(ld_cnt - ldb), 64'd0);

        // Frame C: reset after 7 samples, then a full frame
        ldb = ld_cnt;
        for (int k = 0; k < 7; k++) begin
            send_sample(24'(k + 32), 24'(k));
        end
        send_byte(8'h11);
        send_byte(8'h22);
        chk("C_partial_count", 64'(ld_cnt - ldb), 64'd7);
        chk("C_partial_first", 64'(ld_re[ldb]), 64'h000020);
        #3 rst_n = 1'b0;
        #1;
        chk("C_async_busy", 64'(busy), 64'd0);
        chk("C_async_outputs", {invert_addr, Re_o, Im_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        ldb = ld_cnt;
        sfb = sf_cnt;
        for (int k = 0; k < NP; k++) begin
            send_sample(24'(k + 16), 24'(k));
        end
        tick(4);
        chk("C_load_count", 64'(ld_cnt - ldb), 64'd16);
        chk("C_start_count", 64'(sf_cnt - sfb), 64'd1);
        chk("C_first", {12'd0, ld_addr[ldb], ld_re[ldb], ld_im[ldb]},
            {12'd0, 4'd0, 24'h000010, 24'h000000});
        chk("C_k7", {12'd0, ld_addr[ldb+7], ld_re[ldb+7], ld_im[ldb+7]},
            {12'd0, 4'd14, 24'h000017, 24'h000007});

        chk("never_load_and_start", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
